// File: rtl/ghash_ctrl.sv
// GHASH sequencing controller: feeds (Y ^ X_i) and H to an external pipelined
// GF(2^128) multiplier and folds each product back into the running hash Y.
module ghash_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         iStart,
  input  logic [127:0] iHashkey,
  input  logic         iBlkValid,
  output logic         oBlkReady,
  input  logic [127:0] iBlk,
  input  logic         iLast,
  output logic [127:0] oMulA,
  output logic [127:0] oMulB,
  input  logic [127:0] iMulResult,
  output logic [127:0] oTag,
  output logic         oTagValid,
  output logic         oBusy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    MUL      = 2'd2
  } state_t;

  localparam logic [3:0] LAT_C = 4'(MUL_LAT);

  state_t       state_q;
  logic [127:0] y_q;
  logic [127:0] h_q;
  logic [127:0] mul_a_q;
  logic [127:0] tag_q;
  logic         tag_valid_q;
  logic [3:0]   cnt_q;
  logic         last_q;
  logic         busy_q;

  // Sequencer FSM; all outputs except the ready handshake are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= 128'd0;
      h_q         <= 128'd0;
      mul_a_q     <= 128'd0;
      tag_q       <= 128'd0;
      tag_valid_q <= 1'b0;
      cnt_q       <= 4'd0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tag_valid_q <= 1'b0;
      if (iStart) begin
        // A new message wins over everything, abandoning any in-flight product.
        h_q     <= iHashkey;
        y_q     <= 128'd0;
        last_q  <= 1'b0;
        cnt_q   <= 4'd0;
        state_q <= WAIT_BLK;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          WAIT_BLK: begin
            if (iBlkValid) begin
              mul_a_q <= y_q ^ iBlk;
              last_q  <= iLast;
              cnt_q   <= LAT_C;
              state_q <= MUL;
            end else begin
              state_q <= WAIT_BLK;
            end
            busy_q <= 1'b1;
          end
          MUL: begin
            if (cnt_q > 4'd1) begin
              cnt_q  <= cnt_q - 4'd1;
              busy_q <= 1'b1;
            end else begin
              y_q   <= iMulResult;
              cnt_q <= 4'd0;
              if (last_q) begin
                tag_q       <= iMulResult;
                tag_valid_q <= 1'b1;
                state_q     <= IDLE;
                busy_q      <= 1'b0;
              end else begin
                state_q <= WAIT_BLK;
                busy_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oBlkReady = (state_q == WAIT_BLK) & ~iStart;
  assign oMulA     = mul_a_q;
  assign oMulB     = h_q;
  assign oTag      = tag_q;
  assign oTagValid = tag_valid_q;
  assign oBusy     = busy_q;

endmodule
